// File: rtl/up_counter_3bit.sv
// up_counter_3bit: 3-bit synchronous binary up counter.
//
// Counts 0..7 and wraps to 0, advancing on every rising clk edge while out
// of reset. All three bits share the same clock edge; there is no ripple
// clocking and no enable, load or direction control.
//
// Ports:
//   clk    - single clock; the count advances on its rising edge
//   reset  - asynchronous, active-low clear (Q forced to 000 while 0)
//   Q      - current count value, driven directly from flip-flops
module up_counter_3bit (
    input  logic       clk,
    input  logic       reset,
    output logic [2:0] Q
);

    // Per-bit toggle enables, equivalent to a chain of T flip-flops:
    // a bit flips exactly when every lower bit is 1.
    logic [2:0] toggle;

    always_comb begin
        toggle    = '0;
        toggle[0] = 1'b1;
        toggle[1] = Q[0];
        toggle[2] = Q[1] & Q[0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Q <= '0;
        end else begin
            Q <= Q ^ toggle;
        end
    end

endmodule

// File: tb/tb_up_counter_3bit.sv
// Self-checking bench for up_counter_3bit: directed scenarios followed by
// randomized clocking and asynchronous reset pulses, checked against a
// behavioural modulo-8 count model.
module tb_up_counter_3bit;

    logic       clk;
    logic       reset;
    logic [2:0] Q;

    int unsigned total;
    int unsigned bad;
    int          model;

    up_counter_3bit dut (
        .clk   (clk),
        .reset (reset),
        .Q     (Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_q(input string tag, input logic [2:0] exp);
        total++;
        assert (Q === exp) else begin
            bad++;
            $error("FAIL %s: Q=%b expected %b", tag, Q, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One rising edge; model follows the counting rule, sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
        if (reset) model = (model + 1) % 8;
        else       model = 0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Assert reset between edges and confirm Q clears before the next edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b0;
        model = 0;
        #1;
        check_q(tag, 3'b000);
    endtask

    initial begin
        logic [2:0] seq_exp [8];
        logic [2:0] prev;
        int         tog0, tog1, tog2, wraps;

        total = 0;
        bad   = 0;
        model = 0;
        seq_exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

        // Power-up with reset asserted from time zero.
        reset = 1'b0;
        #1;
        check_q("powerup_t0", 3'b000);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_q("powerup_hold", 3'b000);
        end

        // Count sequence over the first 8 edges, also counting bit toggles.
        release_reset();
        tog0 = 0; tog1 = 0; tog2 = 0; wraps = 0;
        for (int i = 0; i < 8; i++) begin
            prev = Q;
            tick();
            check_q("count_seq", seq_exp[i]);
            if (prev[0] != Q[0]) tog0++;
            if (prev[1] != Q[1]) tog1++;
            if (prev[2] != Q[2]) tog2++;
            if (prev == 3'b111 && Q == 3'b000) wraps++;
        end
        check_int("toggle_bit0", tog0, 8);
        check_int("toggle_bit1", tog1, 4);
        check_int("toggle_bit2", tog2, 2);

        // Another 8 edges: 16 total since release, second wrap, ends at 000.
        for (int i = 0; i < 8; i++) begin
            prev = Q;
            tick();
            check_q("wrap_run", 3'(model));
            if (prev == 3'b111 && Q == 3'b000) wraps++;
        end
        check_int("wrap_count", wraps, 2);
        check_q("wrap_end", 3'b000);

        // Async reset at Q = 101.
        for (int i = 0; i < 5; i++) tick();
        check_q("at_101", 3'b101);
        async_reset("async_mid");
        release_reset();
        tick();
        check_q("after_async", 3'b001);

        // Reset held for 5 edges with the clock running.
        for (int i = 0; i < 3; i++) tick();
        async_reset("hold_enter");
        for (int i = 0; i < 5; i++) begin
            tick();
            check_q("hold_running", 3'b000);
        end
        release_reset();
        tick();
        check_q("hold_resume", 3'b001);

        // Randomized edges and reset pulses against the model.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                async_reset("rand_async");
                for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                    tick();
                    check_q("rand_hold", 3'(model));
                end
                release_reset();
            end else begin
                tick();
                check_q("rand_count", 3'(model));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/up_counter_3bit.md
UP_COUNTER_3BIT -- requirements
Module: up_counter_3bit

Interface
REQ-001 Parameters: none; the width is fixed at 3 bits.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge, except reset.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 Port: Q  output  3  current count value, registered.
REQ-005 The block SHALL have exactly one clock (clk) and one reset (reset), which is asynchronous and active-low; no other ports.

Function
REQ-006 The block SHALL be a synchronous binary up counter: all three state bits SHALL be clocked by the same clk edge (no ripple clocking).
REQ-007 While reset is deasserted (1), on each rising clk edge Q SHALL become (Q + 1) modulo 8.
REQ-008 The counting sequence SHALL be 000, 001, 010, 011, 100, 101, 110, 111, then 000, repeating indefinitely.
REQ-009 Wrap-around: on the rising edge with Q = 111, Q SHALL become 000, with no stall cycle and no extra state.
REQ-010 Next-state logic SHALL be toggle-based, equivalent to T flip-flops:
- bit 0 toggles every cycle
- bit 1 toggles when Q[0] = 1
- bit 2 toggles when Q[1:0] = 11
REQ-011 Latency: Q SHALL reflect the new value within the same clock edge that increments it, with no pipeline delay.
REQ-012 Q SHALL be driven directly from flip-flops, with no combinational path from any input to Q other than the reset clear.
REQ-013 There SHALL be no enable, load or direction control; the counter counts every cycle when out of reset.

Reset
REQ-014 When reset = 0, Q SHALL go to 000 immediately, independent of clk.
REQ-015 While reset = 0, Q SHALL hold 000 regardless of clk activity.
REQ-016 Reset asserted mid-count (any Q value) SHALL clear Q to 000 asynchronously; any partial count is discarded.
REQ-017 After reset deasserts (0 -> 1), the first rising clk edge SHALL produce Q = 001.
REQ-018 If reset deasserts coincident with a rising clk edge, that edge MAY be ignored, but Q SHALL be 000 or 001 afterwards, never any other value.
REQ-019 Q SHALL be 000 before the first clock edge whenever reset was asserted at time zero; there are no X values on Q after the first reset assertion.

Verification
REQ-020 Power-up: hold reset = 0 for 2 cycles with clk running at a 10 ns period -> Q = 000 throughout.
REQ-021 Count sequence: release reset, then apply 8 rising edges -> Q = 001, 010, 011, 100, 101, 110, 111, 000, in that order.
REQ-022 Wrap: run 16 edges after release -> Q passes 111 -> 000 twice and ends at 000.
REQ-023 Async reset mid-count: at Q = 101, drive reset = 0 between clock edges -> Q = 000 before the next edge; release -> next edge gives 001.
REQ-024 Reset held with clock running: keep reset = 0 for 5 edges -> Q stays 000; release -> counting resumes from 001.
REQ-025 Bit-toggle check: over one full cycle of 8 edges -> Q[0] toggles 8 times, Q[1] 4 times, Q[2] 2 times.
